// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter sharing one sequential multiplier among N requesters.
// IDLE: pick winner | CLR: clear multiplier | START: start pulse | WAIT: await done/timeout | RESP: ack winner
module mult_share_ctrl #(
  parameter int N       = 4,
  parameter int W       = 5,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   x_bus,
  input  logic [N*W-1:0]   y_bus,
  output logic [N-1:0]     ack,
  output logic [2*W-1:0]   result,
  output logic             err,
  output logic             busy,
  output logic [2:0]       grant_id,
  output logic             mul_rst,
  output logic             mul_start,
  output logic [W-1:0]     mul_x,
  output logic [W-1:0]     mul_y,
  input  logic [2*W-1:0]   mul_result,
  input  logic             mul_done
);

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [2:0]     rr_ptr;
  logic [7:0]     cnt;
  logic           err_q;
  logic [2*N-1:0] req_rot;
  logic           pick_vld;
  logic [2:0]     pick_id;
  logic           done_ok;
  logic           time_out;

  // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
  always_comb begin
    int sum;
    req_rot  = {req, req} >> rr_ptr;
    pick_vld = 1'b0;
    pick_id  = '0;
    sum      = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        sum = int'(rr_ptr) + j;
        if (sum >= N) sum = sum - N;
        pick_vld = 1'b1;
        pick_id  = 3'(sum);
      end
    end
  end

  // A zero count marks the first WAIT cycle, where a stale done is ignored.
  assign done_ok  = (state == WAIT) && (cnt != 8'd0) && mul_done;
  assign time_out = (state == WAIT) && (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = CLR;
      CLR:     state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (done_ok || time_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      result   <= '0;
      mul_x    <= '0;
      mul_y    <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_id;
            mul_x    <= x_bus[int'(pick_id)*W +: W];
            mul_y    <= y_bus[int'(pick_id)*W +: W];
          end
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (done_ok) begin
            result <= mul_result;
            err_q  <= 1'b0;
          end else if (time_out) begin
            result <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP: rr_ptr <= (grant_id == 3'(N - 1)) ? 3'd0 : grant_id + 3'd1;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mul_rst   = (state == CLR);
  assign mul_start = (state == START);
  assign err       = (state == RESP) && err_q;
  assign ack       = (state == RESP) ? ({{(N-1){1'b0}}, 1'b1} << grant_id) : '0;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios plus randomized jobs against a
// rotation/product reference model and a behavioural multiplier.
module tb_mult_share_ctrl;
  localparam int N  = 4;
  localparam int W  = 5;
  localparam int TO = 63;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   x_bus = '0;
  logic [N*W-1:0]   y_bus = '0;
  logic [N-1:0]     ack;
  logic [2*W-1:0]   result;
  logic             err, busy, mul_rst, mul_start;
  logic [2:0]       grant_id;
  logic [W-1:0]     mul_x, mul_y;
  logic [2*W-1:0]   mul_result;
  logic             mul_done = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mode  = 0;   // 0: done after dly cycles, 1: never done, 2: done always high
  int dly   = 20;
  int mcnt  = 0;
  int rr    = 0;   // model priority pointer

  mult_share_ctrl #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .x_bus(x_bus), .y_bus(y_bus),
    .ack(ack), .result(result), .err(err), .busy(busy), .grant_id(grant_id),
    .mul_rst(mul_rst), .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mode == 2) mul_done <= 1'b1;
    else if (mul_rst) begin
      mul_done <= 1'b0;
      mcnt     <= 0;
    end else if (mul_start && mode == 0) mcnt <= dly;
    else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_done <= 1'b1;
    end
  end

  assign mul_result = mul_done ? ({5'b0, mul_x} * {5'b0, mul_y}) : 10'h3A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rnd_bus();
    logic [31:0] v;
    v = $urandom;
    return v[N*W-1:0];
  endfunction

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_ack"}, 32'(ack), 0);
    chk({pfx, "_result"}, 32'(result), 0);
    chk({pfx, "_err"}, 32'(err), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_grant"}, 32'(grant_id), 0);
    chk({pfx, "_mulrst"}, 32'(mul_rst), 0);
    chk({pfx, "_mulstart"}, 32'(mul_start), 0);
    chk({pfx, "_mulx"}, 32'(mul_x), 0);
    chk({pfx, "_muly"}, 32'(mul_y), 0);
  endtask

  // Runs one job end to end; the winner and all expectations come from the model.
  task automatic do_job(input logic [N-1:0] r, input int md, input int d, input bit scramble);
    int w, k, clr_c, exp_lat, exp_res;
    bit seen;
    logic [W-1:0] ex, ey;
    mode = md;
    dly  = d;
    req  = r;
    w = -1;
    for (int i = 0; i < N; i++) begin
      k = (rr + i) % N;
      if (w < 0 && r[k]) w = k;
    end
    ex = x_bus[w*W +: W];
    ey = y_bus[w*W +: W];
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mul_rst) seen = 1'b1;
    end
    chk("clr_seen", 32'(seen), 1);
    if (!seen) return;
    clr_c = cyc;
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("mul_x", 32'(mul_x), 32'(ex));
    chk("mul_y", 32'(mul_y), 32'(ey));
    chk("busy_job", 32'(busy), 1);
    chk("start_in_clr", 32'(mul_start), 0);
    if (scramble) begin
      x_bus = rnd_bus();
      y_bus = rnd_bus();
    end
    @(negedge clk);
    chk("clr_one_cycle", 32'(mul_rst), 0);
    chk("start_pulse", 32'(mul_start), 1);
    @(negedge clk);
    chk("start_one_cycle", 32'(mul_start), 0);
    seen = 1'b0;
    for (int c = 0; c < TO + 20 && !seen; c++) begin
      if (ack != '0) seen = 1'b1;
      else @(negedge clk);
    end
    chk("ack_seen", 32'(seen), 1);
    if (!seen) return;
    exp_lat = (md == 1) ? TO + 2 : (md == 2) ? 4 : d + 3;
    exp_res = (md == 1) ? 0 : int'(ex) * int'(ey);
    chk("latency", 32'(cyc - clr_c), 32'(exp_lat));
    chk("ack_onehot", 32'(ack), 32'(1) << w);
    chk("result", 32'(result), 32'(exp_res));
    chk("err", 32'(err), (md == 1) ? 1 : 0);
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 0);
    chk("idle_gap", 32'(busy), 0);
    chk("err_clear", 32'(err), 0);
    rr = (w + 1) % N;
  endtask

  initial begin
    bit seen;
    logic [N-1:0] r;
    int md;
    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 32'(busy), 0);

    // single request
    x_bus[0*W +: W] = 5'd7;
    y_bus[0*W +: W] = 5'd9;
    do_job(4'b0001, 0, 20, 1'b0);
    req = '0;

    // contention, all requests held
    x_bus = {5'd0, 5'd31, 5'd5, 5'd3};
    y_bus = {5'd17, 5'd31, 5'd6, 5'd4};
    for (int j = 0; j < 4; j++) do_job(4'b1111, 0, 4 + j, 1'b0);
    req = '0;

    // fairness: after 1 is served, 0 beats 1
    do_job(4'b0010, 0, 3, 1'b0);
    do_job(4'b0011, 0, 3, 1'b0);
    req = '0;

    // timeout then normal recovery
    x_bus[2*W +: W] = 5'd11;
    y_bus[2*W +: W] = 5'd13;
    do_job(4'b0100, 1, 0, 1'b0);
    do_job(4'b0100, 0, 5, 1'b0);
    req = '0;

    // stale done held high through CLR/START
    do_job(4'b1000, 2, 0, 1'b0);
    req = '0;
    mode = 0;

    // reset during WAIT
    mode = 1;
    req  = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mul_start) seen = 1'b1;
    end
    chk("rst_test_start", 32'(seen), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    #1;
    rst  = 1'b1;
    req  = '0;
    mode = 0;
    rr   = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_ack_after_rst", 32'(ack), 0);
    end
    x_bus[2*W +: W] = 5'd2;
    y_bus[2*W +: W] = 5'd15;
    do_job(4'b0100, 0, 7, 1'b0);
    req = '0;

    // randomized jobs with operand changes after grant
    for (int it = 0; it < 40; it++) begin
      x_bus = rnd_bus();
      y_bus = rnd_bus();
      r  = 4'($urandom_range(1, 15));
      md = ($urandom_range(0, 9) == 0) ? 1 : ($urandom_range(0, 9) == 0) ? 2 : 0;
      do_job(r, md, int'($urandom_range(1, 30)), 1'b1);
      if ($urandom_range(0, 1) == 1) req = '0;
    end
    req = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
